// File: rtl/spi_pkg.sv
// Shared SPI definitions: command opcodes, upload source IDs and the state
// encodings used by the SPI master and slave handlers.
package spi_pkg;

  localparam logic [7:0] CMD_SPI_WRITE      = 8'h13;
  localparam logic [7:0] CMD_SPI_SLAVE_LOAD = 8'h14;
  localparam logic [7:0] SRC_SPI_MASTER     = 8'h03;
  localparam logic [7:0] SRC_SPI_SLAVE      = 8'h14;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_XFER
  } main_state_t;

  typedef enum logic [1:0] {
    UP_IDLE,
    UP_SEND,
    UP_WAIT
  } up_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/spi_slave_core.sv
// SPI mode-0 slave shifter: input synchronisers, SCLK edge detection and the
// MOSI/MISO shift registers with their bit and byte counters.
module spi_slave_core
  import spi_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  input  logic       xfer_start,
  input  logic       xfer_active,
  input  logic [7:0] tx_byte,
  output logic       cs_sync,
  output logic [7:0] byte_cnt,
  output logic [7:0] rx_byte,
  output logic       rx_strobe,
  output logic       spi_miso,
  output logic       spi_miso_oe
);

  logic       sclk_meta, sclk_s, sclk_d;
  logic       cs_meta, cs_s;
  logic       mosi_meta, mosi_s;
  logic [2:0] bit_cnt;
  logic [7:0] rx_shift;
  logic [7:0] tx_shift;
  logic       sclk_rise, sclk_fall;
  logic       run, stop, wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_meta <= 1'b0;
      sclk_s    <= 1'b0;
      sclk_d    <= 1'b0;
      cs_meta   <= 1'b1;
      cs_s      <= 1'b1;
      mosi_meta <= 1'b0;
      mosi_s    <= 1'b0;
    end else begin
      sclk_meta <= spi_sclk;
      sclk_s    <= sclk_meta;
      sclk_d    <= sclk_s;
      cs_meta   <= spi_cs_n;
      cs_s      <= cs_meta;
      mosi_meta <= spi_mosi;
      mosi_s    <= mosi_meta;
    end
  end

  assign cs_sync   = cs_s;
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign run       = xfer_active & ~cs_s;
  assign stop      = xfer_active & cs_s;
  assign wrap      = run & sclk_rise & (bit_cnt == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt     <= 3'd0;
      byte_cnt    <= 8'd0;
      rx_strobe   <= 1'b0;
      spi_miso    <= 1'b1;
      spi_miso_oe <= 1'b0;
    end else begin
      rx_strobe <= wrap;
      if (xfer_start) begin
        bit_cnt     <= 3'd0;
        byte_cnt    <= 8'd0;
        spi_miso    <= tx_byte[7];
        spi_miso_oe <= 1'b1;
      end else if (stop) begin
        // a partial byte is simply abandoned: no strobe is raised for it
        bit_cnt     <= 3'd0;
        spi_miso    <= 1'b1;
        spi_miso_oe <= 1'b0;
      end else if (run) begin
        if (sclk_rise) begin
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) byte_cnt <= sat_inc8(byte_cnt);
        end else if (sclk_fall) begin
          // bit_cnt already counts the rising edge just seen; 0 means a fresh byte
          spi_miso <= tx_shift[3'd7 - bit_cnt];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (xfer_start || wrap) tx_shift <= tx_byte;
    if (run && sclk_rise) rx_shift <= {rx_shift[6:0], mosi_s};
    if (wrap) rx_byte <= {rx_shift[6:0], mosi_s};
  end

endmodule

// File: rtl/spi_slave_handler.sv
// SPI slave handler: preloaded response buffer shifted out on MISO, received
// bytes queued in an RX FIFO and drained through the upload interface.
module spi_slave_handler #(
  parameter int         BUFFER_SIZE        = 32,
  parameter logic [7:0] CMD_SPI_SLAVE_LOAD = spi_pkg::CMD_SPI_SLAVE_LOAD,
  parameter logic [7:0] UPLOAD_SOURCE      = spi_pkg::SRC_SPI_SLAVE,
  parameter logic [7:0] FILL_BYTE          = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  cmd_type,
  input  logic [15:0] cmd_length,
  input  logic [7:0]  cmd_data,
  input  logic [15:0] cmd_data_index,
  input  logic        cmd_start,
  input  logic        cmd_data_valid,
  input  logic        cmd_done,
  output logic        cmd_ready,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic        rx_overflow,
  output logic        upload_active,
  output logic        upload_req,
  output logic [7:0]  upload_data,
  output logic [7:0]  upload_source,
  output logic        upload_valid,
  input  logic        upload_ready
);

  import spi_pkg::*;

  localparam int AW = $clog2(BUFFER_SIZE);
  localparam int LW = AW + 1;

  main_state_t state, state_nxt;
  up_state_t   up_state, up_state_nxt;

  logic [7:0]    tx_buf [BUFFER_SIZE];
  logic [LW-1:0] tx_len;
  logic [7:0]    tx_idx;
  logic [7:0]    tx_byte;

  logic          cs_sync;
  logic [7:0]    byte_cnt;
  logic [7:0]    rx_byte;
  logic          rx_strobe;
  logic          xfer_start;
  logic          xfer_active;

  logic [7:0]    fifo_mem [BUFFER_SIZE];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          fifo_empty, fifo_full;
  logic          push_ok, pop;

  // Main FSM: selection wins over a new preload, but never interrupts one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (!cs_sync) state_nxt = ST_XFER;
        else if (cmd_start && cmd_type == CMD_SPI_SLAVE_LOAD) state_nxt = ST_LOAD;
      end
      ST_LOAD: if (cmd_done) state_nxt = ST_IDLE;
      ST_XFER: if (cs_sync) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign cmd_ready   = (state != ST_XFER);
  assign xfer_start  = (state == ST_IDLE) && !cs_sync;
  assign xfer_active = (state == ST_XFER);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_len <= '0;
    end else if (state == ST_LOAD && cmd_done) begin
      tx_len <= (cmd_length >= 16'(BUFFER_SIZE)) ? LW'(BUFFER_SIZE) : cmd_length[AW:0];
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_LOAD && cmd_data_valid && cmd_data_index < 16'(BUFFER_SIZE))
      tx_buf[cmd_data_index[AW-1:0]] <= cmd_data;
  end

  // On entry the core loads byte 0; afterwards it reloads the byte that follows byte_cnt.
  assign tx_idx  = (state == ST_IDLE) ? 8'd0 : sat_inc8(byte_cnt);
  assign tx_byte = ({1'b0, tx_idx} < 9'(tx_len)) ? tx_buf[tx_idx[AW-1:0]] : FILL_BYTE;

  spi_slave_core u_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi_sclk    (spi_sclk),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .xfer_start  (xfer_start),
    .xfer_active (xfer_active),
    .tx_byte     (tx_byte),
    .cs_sync     (cs_sync),
    .byte_cnt    (byte_cnt),
    .rx_byte     (rx_byte),
    .rx_strobe   (rx_strobe),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe)
  );

  // RX FIFO: a pop in the same cycle frees the slot a push into a full FIFO needs.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_ok    = rx_strobe && (!fifo_full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rx_overflow <= 1'b0;
    end else begin
      rx_overflow <= rx_strobe && fifo_full && !pop;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr[AW-1:0]] <= rx_byte;
  end

  // Upload FSM: one byte per three cycles, strobe lasts exactly one cycle.
  always_comb begin
    up_state_nxt = up_state;
    pop          = 1'b0;
    unique case (up_state)
      UP_IDLE: begin
        if (!fifo_empty && upload_ready) begin
          pop          = 1'b1;
          up_state_nxt = UP_SEND;
        end
      end
      UP_SEND: up_state_nxt = UP_WAIT;
      UP_WAIT: up_state_nxt = UP_IDLE;
      default: up_state_nxt = UP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_state     <= UP_IDLE;
      upload_req   <= 1'b0;
      upload_valid <= 1'b0;
      upload_data  <= 8'h00;
    end else begin
      up_state <= up_state_nxt;
      if (pop) begin
        upload_req   <= 1'b1;
        upload_valid <= 1'b1;
        upload_data  <= fifo_mem[rd_ptr[AW-1:0]];
      end else begin
        upload_valid <= 1'b0;
        if (up_state == UP_WAIT) upload_req <= 1'b0;
      end
    end
  end

  assign upload_active = !fifo_empty || (up_state != UP_IDLE);
  assign upload_source = UPLOAD_SOURCE;

endmodule

// File: tb/tb_spi_slave_handler.sv
// Bench for spi_slave_handler: a bit-banged mode-0 SPI master, a response/upload
// reference model, a table of directed transfers and randomized transfers.
module tb_spi_slave_handler;

  localparam int BS = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  cmd_type;
  logic [15:0] cmd_length;
  logic [7:0]  cmd_data;
  logic [15:0] cmd_data_index;
  logic        cmd_start, cmd_data_valid, cmd_done, cmd_ready;
  logic        spi_sclk, spi_cs_n, spi_mosi, spi_miso, spi_miso_oe;
  logic        rx_overflow, upload_active, upload_req, upload_valid, upload_ready;
  logic [7:0]  upload_data, upload_source;

  always #5 clk = ~clk;

  spi_slave_handler #(.BUFFER_SIZE(BS)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_type       (cmd_type),
    .cmd_length     (cmd_length),
    .cmd_data       (cmd_data),
    .cmd_data_index (cmd_data_index),
    .cmd_start      (cmd_start),
    .cmd_data_valid (cmd_data_valid),
    .cmd_done       (cmd_done),
    .cmd_ready      (cmd_ready),
    .spi_sclk       (spi_sclk),
    .spi_cs_n       (spi_cs_n),
    .spi_mosi       (spi_mosi),
    .spi_miso       (spi_miso),
    .spi_miso_oe    (spi_miso_oe),
    .rx_overflow    (rx_overflow),
    .upload_active  (upload_active),
    .upload_req     (upload_req),
    .upload_data    (upload_data),
    .upload_source  (upload_source),
    .upload_valid   (upload_valid),
    .upload_ready   (upload_ready)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: response buffer + length, and the bytes still owed upstream.
  logic [7:0] m_buf [BS];
  int         m_len = 0;
  int         m_pend_len = 0;
  logic [7:0] exp_q [$];
  int         exp_ovf = 0;
  int         ovf_cnt = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] got;

  // Byte i of load/mosi/miso sits in bits [8i+7:8i].
  typedef struct packed {
    bit          do_load;
    logic [7:0]  len;
    logic [2:0]  nload;
    logic [31:0] load;
    logic [2:0]  nb;
    logic [47:0] mosi;
    logic [47:0] miso;
  } vec_t;
  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] model_miso(input int k);
    return (k < m_len) ? m_buf[k] : 8'hFF;
  endfunction

  task automatic load_begin(input int len);
    cmd_type = 8'h14; cmd_length = 16'(len); cmd_start = 1'b1;
    tick(1);
    cmd_start = 1'b0;
    m_pend_len = len;
  endtask

  task automatic load_byte(input logic [7:0] d, input int idx);
    cmd_data = d; cmd_data_index = 16'(idx); cmd_data_valid = 1'b1;
    tick(1);
    cmd_data_valid = 1'b0;
    if (idx < BS) m_buf[idx] = d;
  endtask

  task automatic load_end();
    cmd_done = 1'b1;
    tick(1);
    cmd_done = 1'b0;
    tick(1);
    m_len = (m_pend_len < BS) ? m_pend_len : BS;
  endtask

  task automatic spi_bits(input logic [7:0] mo, input int nb, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i > 7 - nb; i--) begin
      spi_mosi = mo[i];
      tick(4);
      mi[i] = spi_miso;
      spi_sclk = 1'b1;
      tick(4);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] mo, output logic [7:0] mi);
    spi_bits(mo, 8, mi);
    if (exp_q.size() >= BS) exp_ovf++;
    else exp_q.push_back(mo);
  endtask

  task automatic cs_on();
    spi_cs_n = 1'b0;
    tick(8);
  endtask

  task automatic cs_off();
    tick(4);
    spi_cs_n = 1'b1;
    tick(6);
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || upload_active) && cyc < 3000) begin
      tick(1);
      cyc++;
    end
    chk("drain_left", exp_q.size(), 0);
    chk("drain_active", upload_active, 0);
  endtask

  always @(negedge clk) begin
    if (rx_overflow) ovf_cnt++;
    if (upload_valid) begin
      chk("upl_expected", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("upl_data", upload_data, exp_q.pop_front());
      chk("upl_source", upload_source, 8'h14);
      chk("upl_req", upload_req, 1);
      chk("upl_valid_width", prev_valid, 0);
    end
    prev_valid <= upload_valid;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cmd_type = 8'h00; cmd_length = 16'd0; cmd_data = 8'h00;
    cmd_data_index = 16'd0; cmd_start = 1'b0; cmd_data_valid = 1'b0; cmd_done = 1'b0;
    spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0; upload_ready = 1'b1;

    vecs[0] = '{1'b1, 8'd3, 3'd3, 32'h003C5AA5, 3'd3, 48'h000000332211, 48'h0000003C5AA5};
    vecs[1] = '{1'b1, 8'd2, 3'd2, 32'h00000201, 3'd5, 48'h005544C3B2A1, 48'h00FFFFFF0201};
    vecs[2] = '{1'b0, 8'd0, 3'd0, 32'h00000000, 3'd3, 48'h0000000C0B0A, 48'h000000FF0201};
    vecs[3] = '{1'b1, 8'd0, 3'd0, 32'h00000000, 3'd2, 48'h000000008001, 48'h00000000FFFF};
    vecs[4] = '{1'b1, 8'd4, 3'd4, 32'h40302010, 3'd6, 48'h665544332211, 48'hFFFF40302010};

    tick(3);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_miso", spi_miso, 1);
    chk("rst_miso_oe", spi_miso_oe, 0);
    chk("rst_upload_req", upload_req, 0);
    chk("rst_upload_valid", upload_valid, 0);
    chk("rst_upload_data", upload_data, 0);
    chk("rst_upload_source", upload_source, 8'h14);
    chk("rst_upload_active", upload_active, 0);
    rst_n = 1'b1;
    tick(3);
    chk("idle_cmd_ready", cmd_ready, 1);

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].do_load) begin
        load_begin(int'(vecs[i].len));
        for (int j = 0; j < int'(vecs[i].nload); j++) load_byte(vecs[i].load[8*j +: 8], j);
        load_end();
      end
      cs_on();
      chk($sformatf("vec%0d_miso_oe", i), spi_miso_oe, 1);
      for (int k = 0; k < int'(vecs[i].nb); k++) begin
        spi_byte(vecs[i].mosi[8*k +: 8], got);
        chk($sformatf("vec%0d_miso%0d", i, k), got, vecs[i].miso[8*k +: 8]);
      end
      cs_off();
      drain();
    end

    // Partial byte: five bits then deselect.
    cs_on();
    spi_bits(8'hB7, 5, got);
    tick(4);
    spi_cs_n = 1'b1;
    tick(3);
    chk("partial_oe_off", spi_miso_oe, 0);
    chk("partial_miso_idle", spi_miso, 1);
    tick(20);
    chk("partial_no_upload", upload_active, 0);

    // Preload attempted while selected must be ignored.
    cs_on();
    chk("sel_cmd_ready", cmd_ready, 0);
    cmd_type = 8'h14; cmd_length = 16'd1; cmd_start = 1'b1;
    tick(1);
    cmd_start = 1'b0; cmd_data = 8'hEE; cmd_data_index = 16'd0; cmd_data_valid = 1'b1;
    tick(1);
    cmd_data_valid = 1'b0; cmd_done = 1'b1;
    tick(1);
    cmd_done = 1'b0;
    chk("sel_cmd_ready_hold", cmd_ready, 0);
    for (int k = 0; k < 2; k++) begin
      spi_byte(8'(8'h60 + k), got);
      chk($sformatf("sel_miso%0d", k), got, model_miso(k));
    end
    cs_off();
    drain();
    cs_on();
    spi_byte(8'h6F, got);
    chk("sel_replay_miso0", got, model_miso(0));
    cs_off();
    drain();

    // Randomized transfers against the model.
    for (int it = 0; it < 6; it++) begin
      int nl;
      int nb;
      nl = $urandom_range(0, 5);
      nb = $urandom_range(1, 6);
      if ($urandom_range(0, 3) != 0) begin
        load_begin(nl);
        for (int j = 0; j < nl; j++) load_byte(8'($urandom), j);
        load_end();
      end
      cs_on();
      for (int k = 0; k < nb; k++) begin
        spi_byte(8'($urandom), got);
        chk($sformatf("rand%0d_miso%0d", it, k), got, model_miso(k));
      end
      cs_off();
      drain();
    end

    // Overflow: full buffer preload with an oversize length and an out-of-range index.
    upload_ready = 1'b0;
    load_begin(40);
    for (int j = 0; j < BS; j++) load_byte(8'(j * 7 + 3), j);
    load_byte(8'hEE, BS);
    load_end();
    exp_ovf = 0;
    ovf_cnt = 0;
    cs_on();
    for (int k = 0; k < BS + 2; k++) begin
      spi_byte(8'(8'h80 + k), got);
      chk($sformatf("ovf_miso%0d", k), got, model_miso(k));
    end
    cs_off();
    tick(10);
    chk("ovf_pulses", ovf_cnt, exp_ovf);
    chk("ovf_fifo_held", upload_active, 1);
    upload_ready = 1'b1;
    drain();

    // Reset in the middle of the second byte.
    upload_ready = 1'b0;
    load_begin(3);
    load_byte(8'hC1, 0);
    load_byte(8'hC2, 1);
    load_byte(8'hC3, 2);
    load_end();
    cs_on();
    spi_byte(8'h5A, got);
    chk("rstmid_miso0", got, 8'hC1);
    spi_bits(8'h3C, 3, got);
    rst_n = 1'b0;
    #1;
    chk("rstmid_cmd_ready", cmd_ready, 1);
    chk("rstmid_miso", spi_miso, 1);
    chk("rstmid_miso_oe", spi_miso_oe, 0);
    chk("rstmid_overflow", rx_overflow, 0);
    chk("rstmid_upload_req", upload_req, 0);
    chk("rstmid_upload_valid", upload_valid, 0);
    chk("rstmid_upload_data", upload_data, 0);
    chk("rstmid_upload_active", upload_active, 0);
    exp_q.delete();
    m_len = 0;
    spi_cs_n = 1'b1;
    spi_sclk = 1'b0;
    tick(3);
    rst_n = 1'b1;
    upload_ready = 1'b1;
    tick(10);
    chk("rstmid_fifo_empty", upload_active, 0);
    cs_on();
    for (int k = 0; k < 2; k++) begin
      spi_byte(8'(8'hD0 + k), got);
      chk($sformatf("rstmid_after_miso%0d", k), got, model_miso(k));
    end
    cs_off();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
